// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_seq
// Purpose : Multi-cycle unsigned multiply / divide sequencer that owns the
//           HI/LO register pair and serves mfhi/mflo/mthi/mtlo moves.
//           Multiply is LSB-first shift-add over a 2*WIDTH accumulator;
//           divide is restoring division (LO = quotient, HI = remainder).
//           One iteration per clock, WIDTH iterations per operation.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start, op, a, b     - operation request (op 0 = mul, 1 = div)
//           hl_rd, hl_wr,       - HI/LO move requests, hl_sel 1 = HI, 0 = LO
//           hl_sel, hl_wdata
//           hl_out              - selected HI/LO value (combinational)
//           busy, done,         - loop running / one-cycle commit pulse /
//           div_zero, stall       divide-by-zero flag with done / PC hold
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hl_rd,
    input  logic             hl_wr,
    input  logic             hl_sel,
    input  logic [WIDTH-1:0] hl_wdata,
    output logic [WIDTH-1:0] hl_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_op;
    logic [WIDTH-1:0] r_m;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] r_acc;  // mul: {partial product, multiplier}; div: low half = quotient/dividend
    logic [WIDTH-1:0] r_rem;    // div partial remainder
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dz;

    logic             w_accept;
    logic             w_last;

    // Multiply step: conditionally add multiplicand to the upper half, then
    // shift the whole accumulator right by one (carry moves into bit 2W-1).
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;

    // Divide step: shift the next dividend bit into the remainder and subtract
    // the divisor when it fits. The shifted-out remainder MSB means the
    // shifted value certainly exceeds any WIDTH-bit divisor.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_accept = start & (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    assign w_shift   = {r_rem, r_acc[WIDTH-1]};
    assign w_ge      = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_m);
    assign w_diff    = w_shift[WIDTH-1:0] - r_m;
    assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, counter and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= 1'b0;
            r_m   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_dz  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_m   <= op ? b : a;
                r_acc <= {{WIDTH{1'b0}}, (op ? a : b)};
                r_rem <= '0;
                r_cnt <= CW'(WIDTH);
                r_dz  <= op & (b == '0);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_op) begin
                    r_rem             <= w_rem_nxt;
                    r_acc[WIDTH-1:0]  <= w_quo_nxt;
                end else begin
                    r_acc <= w_mul_nxt;
                end
                if (w_last) begin
                    if (r_op) begin
                        r_hi <= w_rem_nxt;
                        r_lo <= w_quo_nxt;
                    end else begin
                        r_hi <= w_mul_nxt[2*WIDTH-1:WIDTH];
                        r_lo <= w_mul_nxt[WIDTH-1:0];
                    end
                end
            end

            // Moves are only honoured outside RUN; during RUN they are
            // stalled and the control path reissues them.
            if (hl_wr && (r_state != S_RUN)) begin
                if (hl_sel) r_hi <= hl_wdata;
                else        r_lo <= hl_wdata;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign div_zero = (r_state == S_DONE) & r_dz;
    assign stall    = busy & (start | hl_rd | hl_wr);
    assign hl_out   = hl_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for unsigned 32-bit multiply and divide. Owns the HI/LO register pair and serves HI/LO moves (mfhi/mflo/mthi/mtlo).
- Replaces the single-cycle product/quotient path.
- Control path raises `start` with operands from the register bank (rs/rt).
- Block runs an iterative shift-add or restoring-divide loop and raises `stall` so the PC holds while a dependent HI/LO access waits.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  request a mul/div; sampled when not busy
- op  in  1  0 = multiply, 1 = divide
- a  in  WIDTH  first operand (rs): multiplicand / dividend
- b  in  WIDTH  second operand (rt): multiplier / divisor
- hl_rd  in  1  mfhi/mflo request this cycle
- hl_wr  in  1  mthi/mtlo request this cycle
- hl_sel  in  1  1 = HI, 0 = LO (applies to both hl_rd and hl_wr)
- hl_wdata  in  WIDTH  data for hl_wr
- hl_out  out  WIDTH  selected HI/LO value (combinational from hl_sel)
- busy  out  1  iteration loop running
- done  out  1  one-cycle pulse: result committed to HI/LO
- div_zero  out  1  one-cycle pulse coincident with done when a divide had b==0
- stall  out  1  hold PC/fetch: busy & (start | hl_rd | hl_wr)

Behaviour:
- Reset (rst=1 at posedge, any state):
  - state=IDLE; HI=0, LO=0.
  - busy=0, done=0, div_zero=0; iteration counter=0.
  - An in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
  - busy=1 only in RUN.
  - done=1 only in DONE.
- IDLE or DONE, start=1 at edge E0:
  - Latch a, b and op.
  - Counter=WIDTH; enter RUN.
- RUN: one iteration per edge, counter decrements. At the edge where the counter goes 1→0:
  - HI/LO are written.
  - State→DONE.
  - The WIDTH iterations occupy edges E0+1..E0+WIDTH.
  - busy is high WIDTH cycles.
  - done is high in the cycle after edge E0+WIDTH.
  - Start-to-done latency is WIDTH+1 cycles.
- DONE→IDLE on the next edge unless start=1, in which case the new operation is accepted (back-to-back allowed).
- Multiply, unsigned:
  - 2*WIDTH accumulator, shift-add, LSB-first.
  - Result: HI=product[2W-1:W], LO=product[W-1:0].
- Divide, unsigned restoring:
  - (WIDTH+1)-bit partial remainder.
  - Result: LO=quotient, HI=remainder.
- Divide by zero: no special path; the loop runs the full WIDTH iterations.
  - Result: LO=all ones, HI=a.
  - div_zero pulses with done.
- HI/LO updated only at commit edge, by hl_wr, or by reset. Values stay stable throughout RUN; hl_out shows pre-operation contents during RUN.
- hl_wr while not busy: writes the selected register at the edge.
  - Same edge as an accepted start: the write occurs.
  - The later commit overwrites both HI and LO.
- hl_wr while busy: ignored; stall=1 so the control path reissues it.
- hl_rd while busy: stall=1. hl_out is valid to consume only when stall=0.
- start while busy: ignored, no queueing; stall=1.
- Operands a/b changing during RUN: no effect (latched).
- hl_rd/hl_wr in DONE: not stalled; hl_out returns the committed result.

Test Plan:
- Multiply 7*6: op=0, a=7, b=6, start 1 cycle.
  - busy high 32 cycles, then done pulse.
  - In that cycle: hl_sel=0 → hl_out=42; hl_sel=1 → hl_out=0; div_zero=0.
- Multiply 0xFFFFFFFF*0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - Then back-to-back multiply 0x10000*0x10000 started in the DONE cycle → HI=0x00000001, LO=0, done 33 cycles later.
- Divide 100/7: op=1, a=100, b=7 → LO=14, HI=2 at done.
- Divide by zero: op=1, a=5, b=0 → LO=0xFFFFFFFF, HI=5, div_zero=1 in the same cycle as done, 0 otherwise.
- Contention during RUN of a multiply 3*4:
  - hl_rd=1 → stall=1 every busy cycle, stall=0 in DONE with LO=12.
  - hl_wr (hl_sel=1, data 0xAA) while busy → ignored, HI=0 after commit.
  - Second start while busy → ignored, no extra done.
  - hl_wr HI=0xAA while idle → HI=0xAA next cycle.
- Reset mid-operation: start divide 100/7, assert rst at iteration 10.
  - Next cycle: busy=0, HI=LO=0, state IDLE.
  - No done pulse follows.
  - A fresh start afterwards completes normally.
